phi_tap_controller: RTL and testbench

- Closed-loop controller for the phi0 delay-line tap; finishes the unfinished phase-tracking PLL.
- Consumes the per-cycle phi0→phi2 phase measurement and drives the tap index that selects the delayed phi0 fed to the 6502 model.
- Auto mode: averages measurements, steps the tap to null the error, reports lock.
- Manual mode: the tap follows the debounced up/down buttons.

---
 rtl/godil_pkg.sv | 34 +++
 rtl/diff_averager.sv | 51 +++++
 rtl/phi_tap_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_phi_tap_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/godil_pkg.sv
// godil_pkg: shared types and constants for the phi0 delay-line tap path.
// The tap range constants are also used by the delay-line top and the display.
package godil_pkg;

    // Phase measurement width, in signed eclk ticks.
    localparam int MEAS_W = 16;
    localparam int ERR_W  = MEAS_W + 1;

    // Delay-line tap range.
    localparam int GODIL_TAP_W    = 13;
    localparam int GODIL_TAP_MIN  = 0;
    localparam int GODIL_TAP_MAX  = 4999;
    localparam int GODIL_TAP_INIT = 4686;

    // Tap controller states.
    typedef enum logic [1:0] {
        ST_MANUAL  = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_ADJUST  = 2'd3
    } tap_state_e;

    // Signed phase error of a window average against the target.
    // The result is one bit wider than the average, so it cannot wrap.
    function automatic logic signed [ERR_W-1:0] phase_error(
        input logic signed [MEAS_W-1:0] avg,
        input logic signed [ERR_W-1:0]  target
    );
        logic signed [ERR_W-1:0] avg_x;
        avg_x = ERR_W'(avg);
        return avg_x - target;
    endfunction

endpackage

// File: rtl/diff_averager.sv
// diff_averager: sums 2^AVG_LOG2 phase measurements and exposes the
// floor-rounded average. window_done is combinational so the controller
// can enter its adjust state on the very next cycle.
module diff_averager
    import godil_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                     eclk,
    input  logic                     ereset,
    input  logic                     clear,
    input  logic                     meas_valid,
    input  logic signed [MEAS_W-1:0] meas_diff,
    output logic                     window_done,
    output logic signed [MEAS_W-1:0] avg
);

    // AVG_LOG2 guard bits make overflow impossible for a full window.
    localparam int ACC_W = MEAS_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic signed [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0]        cnt_r;
    logic signed [ACC_W-1:0] diff_ext_s;

    assign diff_ext_s  = ACC_W'(meas_diff);
    assign window_done = meas_valid & ~clear & (cnt_r == CNT_LAST);
    // Arithmetic shift: rounds toward minus infinity.
    assign avg         = MEAS_W'(acc_r >>> AVG_LOG2);

    // Accumulate each accepted sample; clear discards a partial window.
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            acc_r <= ACC_W'(0);
            cnt_r <= CNT_ZERO;
        end else if (clear) begin
            acc_r <= ACC_W'(0);
            cnt_r <= CNT_ZERO;
        end else if (meas_valid) begin
            acc_r <= acc_r + diff_ext_s;
            cnt_r <= (cnt_r == CNT_LAST) ? CNT_ZERO : (cnt_r + CNT_ONE);
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/phi_tap_controller.sv
// phi_tap_controller: closes the phase-tracking loop on the phi0 delay line.
// Auto mode averages phi0->phi2 measurements and steps the tap one position
// per window to null the error; manual mode follows the up/down buttons.
module phi_tap_controller
    import godil_pkg::*;
#(
    parameter int TAP_W      = GODIL_TAP_W,
    parameter int TAP_INIT   = GODIL_TAP_INIT,
    parameter int TAP_MAX    = GODIL_TAP_MAX,
    parameter int AVG_LOG2   = 3,
    parameter int TARGET     = 0,
    parameter int DEADBAND   = 2,
    parameter int LOCK_COUNT = 4,
    parameter int SETTLE     = 2
) (
    input  logic                     eclk,
    input  logic                     ereset,
    input  logic                     auto_en,
    input  logic                     meas_valid,
    input  logic signed [MEAS_W-1:0] meas_diff,
    input  logic                     btn_up,
    input  logic                     btn_dn,
    output logic [TAP_W-1:0]         tap,
    output logic                     locked,
    output logic                     tap_changed,
    output logic                     err_sat
);

    // Tap arithmetic is one bit wider so the clamp check sees -1 and MAX+1.
    localparam int TAP_XW   = TAP_W + 1;
    localparam int SETTLE_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int LOCK_W   = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;

    localparam logic [TAP_XW-1:0]     TAP_MAX_X   = TAP_XW'(TAP_MAX);
    localparam logic [TAP_XW-1:0]     TAP_MIN_X   = TAP_XW'(GODIL_TAP_MIN);
    localparam logic [TAP_XW-1:0]     TAP_ONE_X   = TAP_XW'(1);
    localparam logic [TAP_W-1:0]      TAP_INIT_V  = TAP_W'(TAP_INIT);
    localparam logic [SETTLE_W-1:0]   SETTLE_V    = SETTLE_W'(SETTLE);
    localparam logic [SETTLE_W-1:0]   SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0]   SETTLE_ZERO = SETTLE_W'(0);
    localparam logic [LOCK_W-1:0]     LOCK_V      = LOCK_W'(LOCK_COUNT);
    localparam logic [LOCK_W-1:0]     LOCK_ONE    = LOCK_W'(1);
    localparam logic [LOCK_W-1:0]     LOCK_ZERO   = LOCK_W'(0);
    localparam logic signed [ERR_W-1:0] TARGET_V  = ERR_W'(TARGET);
    localparam logic signed [ERR_W-1:0] DB_POS    = ERR_W'(DEADBAND);
    localparam logic signed [ERR_W-1:0] DB_NEG    = -DB_POS;

    tap_state_e state_r;
    tap_state_e state_nxt_s;

    logic [TAP_W-1:0]    tap_r,        tap_nxt_s;
    logic                locked_r,     locked_nxt_s;
    logic                changed_r,    changed_nxt_s;
    logic                err_sat_r,    err_sat_nxt_s;
    logic [LOCK_W-1:0]   lock_cnt_r,   lock_cnt_nxt_s;
    logic [SETTLE_W-1:0] settle_cnt_r, settle_cnt_nxt_s;
    logic                btn_up_d_r;
    logic                btn_dn_d_r;

    logic                up_edge_s;
    logic                dn_edge_s;
    logic [TAP_XW-1:0]   tap_inc_s;
    logic [TAP_XW-1:0]   tap_dec_s;
    logic                inc_ok_s;
    logic                dec_ok_s;
    logic                acc_clear_s;
    logic                sample_en_s;
    logic                window_done_s;
    logic signed [MEAS_W-1:0] avg_s;
    logic signed [ERR_W-1:0]  err_s;
    logic                in_band_s;
    logic                step_dn_s;
    logic                step_ok_s;
    logic [TAP_W-1:0]    step_tap_s;
    logic [LOCK_W-1:0]   lock_inc_s;

    // Edge history keeps tracking in every state so no stale edge fires later.
    assign up_edge_s = btn_up & ~btn_up_d_r;
    assign dn_edge_s = btn_dn & ~btn_dn_d_r;

    assign tap_inc_s = {1'b0, tap_r} + TAP_ONE_X;
    assign tap_dec_s = {1'b0, tap_r} - TAP_ONE_X;
    assign inc_ok_s  = (tap_inc_s <= TAP_MAX_X);
    assign dec_ok_s  = ~tap_dec_s[TAP_W] & (tap_dec_s >= TAP_MIN_X);

    // Only ACQUIRE with auto_en still high feeds the averager; leaving auto
    // mode in the same cycle drops the sample and the partial window.
    assign acc_clear_s = (state_r != ST_ACQUIRE) | ~auto_en;
    assign sample_en_s = (state_r == ST_ACQUIRE) & auto_en & meas_valid;

    diff_averager #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .eclk        (eclk),
        .ereset      (ereset),
        .clear       (acc_clear_s),
        .meas_valid  (sample_en_s),
        .meas_diff   (meas_diff),
        .window_done (window_done_s),
        .avg         (avg_s)
    );

    // Positive error means phi2 is late, so the loop shortens the delay.
    assign err_s      = phase_error(avg_s, TARGET_V);
    assign in_band_s  = (err_s <= DB_POS) && (err_s >= DB_NEG);
    assign step_dn_s  = (err_s > DB_POS);
    assign step_ok_s  = step_dn_s ? dec_ok_s : inc_ok_s;
    assign step_tap_s = step_dn_s ? tap_dec_s[TAP_W-1:0] : tap_inc_s[TAP_W-1:0];
    assign lock_inc_s = (lock_cnt_r < LOCK_V) ? (lock_cnt_r + LOCK_ONE) : lock_cnt_r;

    // State register.
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            state_r <= ST_MANUAL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; dropping auto_en wins in every auto state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_MANUAL: begin
                if (auto_en) state_nxt_s = ST_SETTLE;
                else         state_nxt_s = ST_MANUAL;
            end
            ST_SETTLE: begin
                if (!auto_en)                                          state_nxt_s = ST_MANUAL;
                else if (settle_cnt_r == SETTLE_ZERO)                  state_nxt_s = ST_ACQUIRE;
                else if (meas_valid && (settle_cnt_r == SETTLE_ONE))   state_nxt_s = ST_ACQUIRE;
                else                                                   state_nxt_s = ST_SETTLE;
            end
            ST_ACQUIRE: begin
                if (!auto_en)           state_nxt_s = ST_MANUAL;
                else if (window_done_s) state_nxt_s = ST_ADJUST;
                else                    state_nxt_s = ST_ACQUIRE;
            end
            ST_ADJUST: begin
                if (!auto_en)       state_nxt_s = ST_MANUAL;
                else if (in_band_s) state_nxt_s = ST_ACQUIRE;
                else if (step_ok_s) state_nxt_s = ST_SETTLE;
                else                state_nxt_s = ST_ACQUIRE;
            end
            default: state_nxt_s = ST_MANUAL;
        endcase
    end

    // Next values of the tap, status outputs and counters for each state.
    always_comb begin
        tap_nxt_s        = tap_r;
        locked_nxt_s     = locked_r;
        changed_nxt_s    = 1'b0;
        err_sat_nxt_s    = err_sat_r;
        lock_cnt_nxt_s   = lock_cnt_r;
        settle_cnt_nxt_s = settle_cnt_r;
        case (state_r)
            ST_MANUAL: begin
                locked_nxt_s   = 1'b0;
                lock_cnt_nxt_s = LOCK_ZERO;
                if (auto_en) settle_cnt_nxt_s = SETTLE_V;
                else         settle_cnt_nxt_s = settle_cnt_r;
                if (up_edge_s && !dn_edge_s && inc_ok_s) begin
                    tap_nxt_s     = tap_inc_s[TAP_W-1:0];
                    changed_nxt_s = 1'b1;
                    err_sat_nxt_s = 1'b0;
                end else if (dn_edge_s && !up_edge_s && dec_ok_s) begin
                    tap_nxt_s     = tap_dec_s[TAP_W-1:0];
                    changed_nxt_s = 1'b1;
                    err_sat_nxt_s = 1'b0;
                end else begin
                    tap_nxt_s = tap_r;
                end
            end
            ST_SETTLE: begin
                if (!auto_en) begin
                    locked_nxt_s   = 1'b0;
                    lock_cnt_nxt_s = LOCK_ZERO;
                end else if (meas_valid && (settle_cnt_r != SETTLE_ZERO)) begin
                    settle_cnt_nxt_s = settle_cnt_r - SETTLE_ONE;
                end else begin
                    settle_cnt_nxt_s = settle_cnt_r;
                end
            end
            ST_ACQUIRE: begin
                if (!auto_en) begin
                    locked_nxt_s   = 1'b0;
                    lock_cnt_nxt_s = LOCK_ZERO;
                end else begin
                    locked_nxt_s = locked_r;
                end
            end
            ST_ADJUST: begin
                if (!auto_en) begin
                    locked_nxt_s   = 1'b0;
                    lock_cnt_nxt_s = LOCK_ZERO;
                end else if (in_band_s) begin
                    lock_cnt_nxt_s = lock_inc_s;
                    locked_nxt_s   = (lock_inc_s == LOCK_V);
                end else begin
                    lock_cnt_nxt_s = LOCK_ZERO;
                    locked_nxt_s   = 1'b0;
                    if (step_ok_s) begin
                        tap_nxt_s        = step_tap_s;
                        changed_nxt_s    = 1'b1;
                        settle_cnt_nxt_s = SETTLE_V;
                    end else begin
                        err_sat_nxt_s = 1'b1;
                    end
                end
            end
            default: begin
                locked_nxt_s   = 1'b0;
                lock_cnt_nxt_s = LOCK_ZERO;
            end
        endcase
    end

    // Datapath registers; buttons reset high so a held button is not an edge.
    always_ff @(posedge eclk or posedge ereset) begin
        if (ereset) begin
            tap_r        <= TAP_INIT_V;
            locked_r     <= 1'b0;
            changed_r    <= 1'b0;
            err_sat_r    <= 1'b0;
            lock_cnt_r   <= LOCK_ZERO;
            settle_cnt_r <= SETTLE_ZERO;
            btn_up_d_r   <= 1'b1;
            btn_dn_d_r   <= 1'b1;
        end else begin
            tap_r        <= tap_nxt_s;
            locked_r     <= locked_nxt_s;
            changed_r    <= changed_nxt_s;
            err_sat_r    <= err_sat_nxt_s;
            lock_cnt_r   <= lock_cnt_nxt_s;
            settle_cnt_r <= settle_cnt_nxt_s;
            btn_up_d_r   <= btn_up;
            btn_dn_d_r   <= btn_dn;
        end
    end

    assign tap         = tap_r;
    assign locked      = locked_r;
    assign tap_changed = changed_r;
    assign err_sat     = err_sat_r;

endmodule

// File: tb/tb_phi_tap_controller.sv
// tb_phi_tap_controller: scenario tasks for the phi0 tap controller.
// Expected tap values are queued when a tap-changing stimulus is driven and
// popped by a monitor on every tap_changed pulse.
module tb_phi_tap_controller;

    localparam int TAP_W = 13;
    localparam logic [TAP_W-1:0] TAP_INIT = 13'd4686;

    logic eclk        = 1'b0;
    logic ereset      = 1'b0;
    logic auto_en     = 1'b0;
    logic meas_valid  = 1'b0;
    logic btn_up      = 1'b0;
    logic btn_dn      = 1'b0;
    logic signed [15:0] meas_diff = 16'sd0;
    logic [TAP_W-1:0] tap;
    logic locked;
    logic tap_changed;
    logic err_sat;

    int checks   = 0;
    int failures = 0;
    logic [TAP_W-1:0] exp_q[$];
    logic [TAP_W-1:0] mon_exp;

    phi_tap_controller dut (
        .eclk        (eclk),
        .ereset      (ereset),
        .auto_en     (auto_en),
        .meas_valid  (meas_valid),
        .meas_diff   (meas_diff),
        .btn_up      (btn_up),
        .btn_dn      (btn_dn),
        .tap         (tap),
        .locked      (locked),
        .tap_changed (tap_changed),
        .err_sat     (err_sat)
    );

    always #5 eclk = ~eclk;

    // Scoreboard monitor: every pulse must match the next queued tap value.
    always @(negedge eclk) begin
        if (!ereset && tap_changed === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse tap=%0d expected no tap_changed", tap);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tap !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_tap got=%0d expected=%0d", tap, mon_exp);
                end
            end
        end
    end

    task automatic send_sample(input logic signed [15:0] d);
        @(posedge eclk); #1;
        meas_valid = 1'b1;
        meas_diff  = d;
        @(posedge eclk); #1;
        meas_valid = 1'b0;
        meas_diff  = 16'sd0;
    endtask

    task automatic send_window(input logic signed [15:0] base, input logic signed [15:0] last);
        for (int i = 0; i < 7; i++) send_sample(base);
        send_sample(last);
    endtask

    task automatic press_up();
        @(posedge eclk); #1; btn_up = 1'b1;
        @(posedge eclk); #1; btn_up = 1'b0;
    endtask

    task automatic press_dn();
        @(posedge eclk); #1; btn_dn = 1'b1;
        @(posedge eclk); #1; btn_dn = 1'b0;
    endtask

    task automatic test_reset();
        logic seen;
        btn_up = 1'b1;
        #2 ereset = 1'b1;
        #4;
        checks++; if (tap !== TAP_INIT) begin failures++; $display("FAIL reset_tap got=%0d expected=%0d", tap, TAP_INIT); end
        checks++; if (locked !== 1'b0 || tap_changed !== 1'b0 || err_sat !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b expected=000", locked, tap_changed, err_sat); end
        @(posedge eclk); #1; ereset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge eclk);
            if (tap_changed !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || tap !== TAP_INIT) begin failures++; $display("FAIL reset_held_btn pulse=%b tap=%0d expected pulse=0 tap=%0d", seen, tap, TAP_INIT); end
        btn_up = 1'b0;
    endtask

    task automatic test_lock_in();
        auto_en = 1'b1;
        send_sample(16'sd99);
        send_sample(16'sd99);
        for (int i = 0; i < 7; i++) send_sample(16'sd10);
        exp_q.push_back(13'd4685);
        send_sample(16'sd10);
        @(negedge eclk);
        checks++; if (tap !== TAP_INIT || tap_changed !== 1'b0) begin failures++; $display("FAIL lockin_adjust_cycle tap=%0d pulse=%b expected tap=%0d pulse=0", tap, tap_changed, TAP_INIT); end
        @(negedge eclk);
        checks++; if (tap !== 13'd4685) begin failures++; $display("FAIL lockin_tap got=%0d expected=4685", tap); end
        checks++; if (tap_changed !== 1'b1) begin failures++; $display("FAIL lockin_pulse got=%b expected=1", tap_changed); end
        @(negedge eclk);
        checks++; if (tap_changed !== 1'b0) begin failures++; $display("FAIL lockin_pulse_width got=%b expected=0", tap_changed); end
    endtask

    task automatic test_lock_acquire();
        send_sample(16'sd99);
        send_sample(16'sd99);
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 8; i++) send_sample((i % 2 == 0) ? 16'sd3 : -16'sd3);
            @(negedge eclk);
            @(negedge eclk);
            checks++; if (locked !== ((w == 3) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL lock_window%0d got=%b expected=%b", w, locked, (w == 3)); end
            checks++; if (tap !== 13'd4685) begin failures++; $display("FAIL lock_tap%0d got=%0d expected=4685", w, tap); end
        end
        exp_q.push_back(13'd4686);
        send_window(-16'sd20, -16'sd20);
        @(negedge eclk);
        @(negedge eclk);
        checks++; if (tap !== 13'd4686 || locked !== 1'b0) begin failures++; $display("FAIL unlock tap=%0d locked=%b expected tap=4686 locked=0", tap, locked); end
    endtask

    task automatic test_rounding();
        send_sample(16'sd77);
        send_sample(16'sd77);
        send_window(-16'sd1, -16'sd1);      // sum -8  -> avg -1
        @(negedge eclk); @(negedge eclk);
        checks++; if (tap !== 13'd4686) begin failures++; $display("FAIL round_m8 got=%0d expected=4686", tap); end
        send_window(-16'sd1, -16'sd2);      // sum -9  -> avg -2
        @(negedge eclk); @(negedge eclk);
        checks++; if (tap !== 13'd4686) begin failures++; $display("FAIL round_m9 got=%0d expected=4686", tap); end
        send_window(16'sd3, 16'sd2);        // sum +23 -> avg +2
        @(negedge eclk); @(negedge eclk);
        checks++; if (tap !== 13'd4686) begin failures++; $display("FAIL round_p23 got=%0d expected=4686", tap); end
        exp_q.push_back(13'd4685);
        send_window(16'sd3, 16'sd3);        // sum +24 -> avg +3
        @(negedge eclk); @(negedge eclk);
        checks++; if (tap !== 13'd4685) begin failures++; $display("FAIL round_p24 got=%0d expected=4685", tap); end
        send_sample(16'sd77);
        send_sample(16'sd77);
        exp_q.push_back(13'd4686);
        send_window(-16'sd2, -16'sd3);      // sum -17 -> avg -3
        @(negedge eclk); @(negedge eclk);
        checks++; if (tap !== 13'd4686) begin failures++; $display("FAIL round_m17 got=%0d expected=4686", tap); end
    endtask

    task automatic test_manual();
        auto_en = 1'b0;
        @(posedge eclk); #1;
        exp_q.push_back(13'd4687);
        btn_up = 1'b1;
        repeat (100) @(posedge eclk);
        #1; btn_up = 1'b0;
        @(negedge eclk);
        checks++; if (tap !== 13'd4687) begin failures++; $display("FAIL manual_hold got=%0d expected=4687", tap); end
        @(posedge eclk); #1;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        repeat (3) @(negedge eclk);
        checks++; if (tap !== 13'd4687) begin failures++; $display("FAIL manual_both got=%0d expected=4687", tap); end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (2) @(negedge eclk);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL manual_drain pending=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_drop_auto();
        auto_en = 1'b1;
        send_sample(16'sd77);
        send_sample(16'sd77);
        for (int i = 0; i < 4; i++) send_sample(16'sd100);
        @(posedge eclk); #1;
        auto_en    = 1'b0;
        meas_valid = 1'b1;
        meas_diff  = 16'sd100;
        @(posedge eclk); #1;
        meas_valid = 1'b0;
        meas_diff  = 16'sd0;
        exp_q.push_back(13'd4688);
        btn_up = 1'b1;
        @(negedge eclk);
        checks++; if (tap !== 13'd4687) begin failures++; $display("FAIL drop_tap_held got=%0d expected=4687", tap); end
        @(posedge eclk); #1;
        btn_up = 1'b0;
        @(negedge eclk);
        checks++; if (tap !== 13'd4688) begin failures++; $display("FAIL drop_manual_next got=%0d expected=4688", tap); end
        auto_en = 1'b1;
        send_sample(16'sd77);
        send_sample(16'sd77);
        send_window(16'sd0, 16'sd0);
        @(negedge eclk); @(negedge eclk);
        checks++; if (tap !== 13'd4688) begin failures++; $display("FAIL drop_fresh_window got=%0d expected=4688", tap); end
        auto_en = 1'b0;
        repeat (2) @(negedge eclk);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 311; i++) begin
            exp_q.push_back(TAP_W'(4689 + i));
            press_up();
        end
        press_up();
        @(negedge eclk);
        checks++; if (tap !== 13'd4999 || tap_changed !== 1'b0) begin failures++; $display("FAIL sat_manual_max tap=%0d pulse=%b expected tap=4999 pulse=0", tap, tap_changed); end
        auto_en = 1'b1;
        send_sample(16'sd77);
        send_sample(16'sd77);
        send_window(-16'sd50, -16'sd50);
        @(negedge eclk); @(negedge eclk);
        checks++; if (tap !== 13'd4999 || tap_changed !== 1'b0) begin failures++; $display("FAIL sat_auto_max tap=%0d pulse=%b expected tap=4999 pulse=0", tap, tap_changed); end
        checks++; if (err_sat !== 1'b1) begin failures++; $display("FAIL sat_flag_max got=%b expected=1", err_sat); end
        auto_en = 1'b0;
        exp_q.push_back(13'd4998);
        press_dn();
        @(negedge eclk);
        checks++; if (tap !== 13'd4998 || err_sat !== 1'b0) begin failures++; $display("FAIL sat_clear tap=%0d err_sat=%b expected tap=4998 err_sat=0", tap, err_sat); end
        for (int i = 0; i < 4998; i++) begin
            exp_q.push_back(TAP_W'(4997 - i));
            press_dn();
        end
        press_dn();
        @(negedge eclk);
        checks++; if (tap !== 13'd0 || tap_changed !== 1'b0) begin failures++; $display("FAIL sat_manual_min tap=%0d pulse=%b expected tap=0 pulse=0", tap, tap_changed); end
        auto_en = 1'b1;
        send_sample(16'sd77);
        send_sample(16'sd77);
        send_window(16'sd50, 16'sd50);
        @(negedge eclk); @(negedge eclk);
        checks++; if (tap !== 13'd0 || err_sat !== 1'b1) begin failures++; $display("FAIL sat_auto_min tap=%0d err_sat=%b expected tap=0 err_sat=1", tap, err_sat); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sat_drain pending=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        for (int w = 0; w < 4; w++) send_window(16'sd0, 16'sd0);
        @(negedge eclk); @(negedge eclk);
        checks++; if (locked !== 1'b1 || err_sat !== 1'b1) begin failures++; $display("FAIL midrst_pre locked=%b err_sat=%b expected 1 1", locked, err_sat); end
        for (int i = 0; i < 3; i++) send_sample(16'sd5);
        btn_up = 1'b1;
        @(posedge eclk); #3;
        ereset  = 1'b1;
        auto_en = 1'b0;
        #1;
        checks++; if (tap !== TAP_INIT) begin failures++; $display("FAIL midrst_tap got=%0d expected=%0d", tap, TAP_INIT); end
        checks++; if (locked !== 1'b0 || err_sat !== 1'b0 || tap_changed !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%b%b%b expected=000", locked, err_sat, tap_changed); end
        @(posedge eclk); #1; ereset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge eclk);
            if (tap_changed !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || tap !== TAP_INIT) begin failures++; $display("FAIL midrst_held_btn pulse=%b tap=%0d expected pulse=0 tap=%0d", seen, tap, TAP_INIT); end
        btn_up = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_lock_in();
        test_lock_acquire();
        test_rounding();
        test_manual();
        test_drop_auto();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time bound for the whole run.
    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
